// File: rtl/sdp_pipe3.sv
// rtl/sdp_pipe3.sv - three-stage pipelined 8-bit select-datapath F(ctl_1, ctl_2, a, b, c)
// Stage 1: a*b, a+b, a-b; stage 2: four candidates; stage 3: mode-selected result.
module sdp_pipe3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctl_1,
  input  logic       ctl_2,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] out
);

  logic [7:0] prod_d, prod_q;
  logic [7:0] sum_d, sum_q;
  logic [7:0] diff_d, diff_q;
  logic [7:0] c1_q;
  logic [1:0] mode1_q;

  logic [7:0] cand0_d, cand0_q;
  logic [7:0] cand1_d, cand1_q;
  logic [7:0] cand2_d, cand2_q;
  logic [7:0] cand3_d, cand3_q;
  logic [1:0] mode2_q;

  logic [7:0] out_d, out_q;

  // Operands are 8 bits and the targets are 8 bits, so every op wraps mod 256.
  always_comb begin
    prod_d  = a * b;
    sum_d   = a + b;
    diff_d  = a - b;
    cand0_d = sum_q + c1_q;
    cand1_d = prod_q + c1_q;
    cand2_d = diff_q ^ c1_q;
    cand3_d = prod_q - c1_q;
    out_d   = 8'h00;
    case (mode2_q)
      2'b00:   out_d = cand0_q;
      2'b01:   out_d = cand1_q;
      2'b10:   out_d = cand2_q;
      default: out_d = cand3_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= 8'h00;
      sum_q   <= 8'h00;
      diff_q  <= 8'h00;
      c1_q    <= 8'h00;
      mode1_q <= 2'b00;
      cand0_q <= 8'h00;
      cand1_q <= 8'h00;
      cand2_q <= 8'h00;
      cand3_q <= 8'h00;
      mode2_q <= 2'b00;
      out_q   <= 8'h00;
    end else begin
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      c1_q    <= c;
      mode1_q <= {ctl_1, ctl_2};
      cand0_q <= cand0_d;
      cand1_q <= cand1_d;
      cand2_q <= cand2_d;
      cand3_q <= cand3_d;
      mode2_q <= mode1_q;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sdp_pipe3.sv
// tb/tb_sdp_pipe3.sv - self-checking bench for sdp_pipe3 against a queue-based delay-line model
module tb_sdp_pipe3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctl_1 = 1'b0;
  logic       ctl_2 = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] c = 8'h00;
  logic [7:0] out;

  int n_checks = 0;
  int n_fail = 0;

  sdp_pipe3 dut (
    .clk   (clk),
    .reset (reset),
    .ctl_1 (ctl_1),
    .ctl_2 (ctl_2),
    .a     (a),
    .b     (b),
    .c     (c),
    .out   (out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_ref(input logic [1:0] m, input int x, input int y, input int z);
    int r;
    case (m)
      2'd0:    r = x + y + z;
      2'd1:    r = (x * y) + z;
      2'd2:    r = ((x - y) & 255) ^ z;
      default: r = (x * y) - z;
    endcase
    return 8'(r & 255);
  endfunction

  // Two results are in flight between edges; a reset edge empties the line and shows 0.
  logic [7:0] dl[$] = '{8'h00, 8'h00};
  logic [7:0] exp_out = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      dl = '{8'h00, 8'h00};
      exp_out = 8'h00;
    end else begin
      dl.push_back(f_ref({ctl_1, ctl_2}, int'(a), int'(b), int'(c)));
      exp_out = dl.pop_front();
    end
  end

  always @(posedge clk) begin
    #1;
    n_checks++;
    if (out !== exp_out) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t out=%02h expected=%02h", $time, out, exp_out);
    end
  end

  task automatic cyc(input logic r, input logic [1:0] m, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] z);
    reset = r;
    {ctl_1, ctl_2} = m;
    a = x;
    b = y;
    c = z;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [7:0] expv);
    n_checks++;
    if (out !== expv) begin
      n_fail++;
      $display("FAIL %s out=%02h expected=%02h", name, out, expv);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic single(input string name, input logic [1:0] m, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] z, input logic [7:0] expv);
    cyc(1'b0, m, x, y, z);
    idle();
    idle();
    lit(name, expv);
  endtask

  initial begin
    cyc(1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
    lit("reset_state", 8'h00);
    idle();
    idle();
    idle();

    cyc(1'b0, 2'd0, 8'd10, 8'd20, 8'd30);
    idle();
    lit("m00_not_early", 8'h00);
    idle();
    lit("m00_sum", 8'h3C);

    single("m01_wrap", 2'd1, 8'd16, 8'd16, 8'd5, 8'h05);
    single("m01_ffxff", 2'd1, 8'hFF, 8'hFF, 8'h00, 8'h01);
    single("m10_wrap", 2'd2, 8'd5, 8'd7, 8'h0F, 8'hF1);
    single("m11_wrap", 2'd3, 8'd3, 8'd4, 8'd20, 8'hF8);

    cyc(1'b0, 2'd0, 8'd3, 8'd4, 8'd20);
    cyc(1'b0, 2'd1, 8'd3, 8'd4, 8'd20);
    cyc(1'b0, 2'd2, 8'd3, 8'd4, 8'd20);
    lit("b2b_m00", 8'h1B);
    cyc(1'b0, 2'd3, 8'd3, 8'd4, 8'd20);
    lit("b2b_m01", 8'h20);
    idle();
    lit("b2b_m10", 8'hEB);
    idle();
    lit("b2b_m11", 8'hF8);

    cyc(1'b0, 2'd1, 8'd7, 8'd9, 8'd3);
    cyc(1'b0, 2'd0, 8'd50, 8'd60, 8'd70);
    cyc(1'b0, 2'd2, 8'd9, 8'd1, 8'd2);
    cyc(1'b1, 2'd3, 8'd11, 8'd12, 8'd13);
    lit("rst_k", 8'h00);
    cyc(1'b0, 2'd0, 8'd1, 8'd1, 8'd1);
    lit("rst_k1", 8'h00);
    cyc(1'b0, 2'd1, 8'd5, 8'd5, 8'd5);
    lit("rst_k2", 8'h00);
    cyc(1'b0, 2'd0, 8'd9, 8'd9, 8'd9);
    lit("rst_k3", 8'h03);

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(99) == 0, 2'($urandom_range(3)), 8'($urandom_range(255)),
          8'($urandom_range(255)), 8'($urandom_range(255)));
    end
    idle();
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
